// File: rtl/bfsh_block_sequencer_if.sv
// Host-side block stream for the Blowfish sequencer: input blocks (s_*) and output blocks (m_*).
interface bfsh_block_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;

  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/bfsh_block_sequencer.sv
// Blowfish host controller: key load and init wait, then one 64-bit block at a time through the
// core with ECB/CBC chaining; strobes and completion are recovered from core_busy.
module bfsh_block_sequencer #(
  parameter int KEY_HOLD     = 2,
  parameter int PT_HOLD      = 2,
  parameter int INIT_CYCLES  = 8192,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  bfsh_block_sequencer_if.slave        bus,
  input  logic [63:0]                  key_in,
  input  logic                         key_load,
  input  logic [63:0]                  iv_in,
  input  logic                         iv_load,
  input  logic                         mode_cbc,
  input  logic                         dir_enc,
  output logic                         key_ready,
  output logic                         seq_busy,
  output logic                         err_timeout,
  output logic                         core_en_key,
  output logic [63:0]                  core_key,
  output logic                         core_en_pt,
  output logic [63:0]                  core_pt,
  output logic                         core_en_enc_dec,
  input  logic                         core_initializing,
  input  logic                         core_busy,
  input  logic [63:0]                  core_ct
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_KEY_PULSE = 3'd1;
  localparam logic [2:0] S_KEY_WAIT  = 3'd2;
  localparam logic [2:0] S_READY     = 3'd3;
  localparam logic [2:0] S_PT_PULSE  = 3'd4;
  localparam logic [2:0] S_PT_START  = 3'd5;
  localparam logic [2:0] S_PT_DONE   = 3'd6;
  localparam logic [2:0] S_OUT       = 3'd7;

  logic [2:0]  state, state_nxt;
  logic [7:0]  hold_cnt;
  logic [15:0] init_cnt;
  logic [9:0]  to_cnt;
  logic [63:0] chain, chain_now, blk_data;
  logic        blk_enc, blk_cbc;
  logic        timeout, in_wait, nxt_wait, expired, accept, key_take, capture;

  // Init progress is tracked purely by the fixed counter plus core_busy.
  logic unused_status;
  assign unused_status = core_initializing;

  assign timeout   = (to_cnt == 10'(BUSY_TIMEOUT));
  assign in_wait   = (state == S_PT_START) || (state == S_PT_DONE);
  assign nxt_wait  = (state_nxt == S_PT_START) || (state_nxt == S_PT_DONE);
  assign expired   = in_wait && (state_nxt == S_READY);
  assign key_take  = ((state == S_IDLE) || (state == S_READY)) && key_load;
  assign accept    = (state == S_READY) && !key_load && bus.s_valid;
  assign capture   = (state == S_PT_DONE) && !core_busy;
  // An IV loaded in the same cycle as a block applies to that block.
  assign chain_now = iv_load ? iv_in : chain;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (key_load) state_nxt = S_KEY_PULSE;
      S_KEY_PULSE: if (hold_cnt == 8'(KEY_HOLD - 1)) state_nxt = S_KEY_WAIT;
      S_KEY_WAIT:  if ((init_cnt == 16'(INIT_CYCLES)) && !core_busy) state_nxt = S_READY;
      S_READY: begin
        if (key_load)         state_nxt = S_KEY_PULSE;
        else if (bus.s_valid) state_nxt = S_PT_PULSE;
      end
      S_PT_PULSE:  if (hold_cnt == 8'(PT_HOLD - 1)) state_nxt = S_PT_START;
      S_PT_START: begin
        if (timeout)        state_nxt = S_READY;
        else if (core_busy) state_nxt = S_PT_DONE;
      end
      S_PT_DONE: begin
        if (!core_busy)     state_nxt = S_OUT;
        else if (timeout)   state_nxt = S_READY;
      end
      S_OUT:       if (bus.m_ready) state_nxt = S_READY;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      hold_cnt        <= '0;
      init_cnt        <= '0;
      to_cnt          <= '0;
      chain           <= '0;
      blk_data        <= '0;
      blk_enc         <= 1'b0;
      blk_cbc         <= 1'b0;
      bus.s_ready     <= 1'b0;
      bus.m_valid     <= 1'b0;
      bus.m_data      <= '0;
      key_ready       <= 1'b0;
      seq_busy        <= 1'b0;
      err_timeout     <= 1'b0;
      core_en_key     <= 1'b0;
      core_key        <= '0;
      core_en_pt      <= 1'b0;
      core_pt         <= '0;
      core_en_enc_dec <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state_nxt != state) ? 8'd0 : hold_cnt + 8'd1;
      if (state_nxt != state)
        init_cnt <= '0;
      else if ((state == S_KEY_WAIT) && (init_cnt != 16'(INIT_CYCLES)))
        init_cnt <= init_cnt + 16'd1;
      to_cnt   <= (in_wait && nxt_wait) ? to_cnt + 10'd1 : 10'd0;

      // Status and strobes follow the next state so they are registered yet cycle-exact.
      bus.s_ready <= (state_nxt == S_READY);
      bus.m_valid <= (state_nxt == S_OUT);
      seq_busy    <= (state_nxt != S_IDLE) && (state_nxt != S_READY);
      key_ready   <= (state_nxt == S_READY) || (state_nxt == S_PT_PULSE) ||
                     (state_nxt == S_PT_START) || (state_nxt == S_PT_DONE) || (state_nxt == S_OUT);
      core_en_key <= (state_nxt == S_KEY_PULSE);
      core_en_pt  <= (state_nxt == S_PT_PULSE);

      if (key_take) begin
        core_key    <= key_in;
        err_timeout <= 1'b0;
      end else if (expired) begin
        err_timeout <= 1'b1;
      end

      if ((state == S_READY) && iv_load)
        chain <= iv_in;

      if (accept) begin
        blk_data        <= bus.s_data;
        blk_enc         <= dir_enc;
        blk_cbc         <= mode_cbc;
        core_en_enc_dec <= dir_enc;
        core_pt         <= (dir_enc && mode_cbc) ? (bus.s_data ^ chain_now) : bus.s_data;
      end

      if (capture)
        bus.m_data <= (!blk_enc && blk_cbc) ? (core_ct ^ chain) : core_ct;

      // Chain advances only when the output block is actually taken.
      if ((state == S_OUT) && bus.m_ready && blk_cbc)
        chain <= blk_enc ? bus.m_data : blk_data;
    end
  end

endmodule

// File: tb/tb_bfsh_block_sequencer.sv
// Bench for bfsh_block_sequencer: behavioural core stand-in with an invertible toy cipher and
// an ECB/CBC mode reference model, randomized blocks, stalls, resets and timeouts.
module tb_bfsh_block_sequencer;
  localparam int KEY_HOLD     = 2;
  localparam int PT_HOLD      = 3;
  localparam int INIT_CYCLES  = 64;
  localparam int BUSY_TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0, iv_in = '0;
  logic        key_load = 1'b0, iv_load = 1'b0, mode_cbc = 1'b0, dir_enc = 1'b0;
  logic        key_ready, seq_busy, err_timeout, core_en_key, core_en_pt, core_en_enc_dec;
  logic [63:0] core_key, core_pt, core_ct;
  logic        core_initializing, core_busy;

  bfsh_block_sequencer_if bus ();

  bfsh_block_sequencer #(
    .KEY_HOLD(KEY_HOLD), .PT_HOLD(PT_HOLD), .INIT_CYCLES(INIT_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .key_in(key_in), .key_load(key_load), .iv_in(iv_in), .iv_load(iv_load),
    .mode_cbc(mode_cbc), .dir_enc(dir_enc),
    .key_ready(key_ready), .seq_busy(seq_busy), .err_timeout(err_timeout),
    .core_en_key(core_en_key), .core_key(core_key), .core_en_pt(core_en_pt), .core_pt(core_pt),
    .core_en_enc_dec(core_en_enc_dec), .core_initializing(core_initializing),
    .core_busy(core_busy), .core_ct(core_ct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Toy invertible block cipher standing in for Blowfish.
  function automatic logic [63:0] enc_f(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] t;
    t = x ^ k;
    return {t[50:0], t[63:51]} + 64'h9E3779B97F4A7C15;
  endfunction

  function automatic logic [63:0] dec_f(input logic [63:0] y, input logic [63:0] k);
    logic [63:0] t;
    t = y - 64'h9E3779B97F4A7C15;
    return {t[12:0], t[63:13]} ^ k;
  endfunction

  // Core stand-in: acts on falling edges of its strobes, reports busy, ct valid when busy drops.
  logic [63:0] ck, cpt;
  logic        cenc, ek_d, ep_d;
  int          init_left, pt_left;
  bit          core_dead = 1'b0;
  int          core_init_len = 10;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ek_d <= 1'b0; ep_d <= 1'b0; core_busy <= 1'b0; core_initializing <= 1'b0;
      core_ct <= '0; init_left <= 0; pt_left <= 0; ck <= '0; cpt <= '0; cenc <= 1'b0;
    end else begin
      ek_d <= core_en_key;
      ep_d <= core_en_pt;
      if (ek_d && !core_en_key) begin
        ck <= core_key; core_busy <= 1'b1; core_initializing <= 1'b1; init_left <= core_init_len;
      end else if (init_left > 0) begin
        init_left <= init_left - 1;
        if (init_left == 1) begin core_busy <= 1'b0; core_initializing <= 1'b0; end
      end
      if (ep_d && !core_en_pt && !core_dead) begin
        cpt <= core_pt; cenc <= core_en_enc_dec; core_busy <= 1'b1;
        pt_left <= int'($urandom_range(5, 1));
      end else if (pt_left > 0) begin
        pt_left <= pt_left - 1;
        if (pt_left == 1) begin
          core_busy <= 1'b0;
          core_ct   <= cenc ? enc_f(cpt, ck) : dec_f(cpt, ck);
        end
      end
    end
  end

  // Observation counters, written only here.
  int pt_w_cnt = 0, last_pt_w = 0, mv_cnt = 0, ek_cnt = 0;
  always @(negedge clk) begin
    if (core_en_pt) pt_w_cnt <= pt_w_cnt + 1;
    else if (pt_w_cnt != 0) begin last_pt_w <= pt_w_cnt; pt_w_cnt <= 0; end
    if (bus.m_valid) mv_cnt <= mv_cnt + 1;
    if (core_en_key) ek_cnt <= ek_cnt + 1;
  end

  // Mode reference model.
  logic [63:0] m_chain = '0, m_key = '0;

  task automatic model_step(input logic [63:0] p, input bit enc, input bit cbc, output logic [63:0] exp);
    if (!cbc) exp = enc ? enc_f(p, m_key) : dec_f(p, m_key);
    else if (enc) begin exp = enc_f(p ^ m_chain, m_key); m_chain = exp; end
    else begin exp = dec_f(p, m_key) ^ m_chain; m_chain = p; end
  endtask

  task automatic load_key(input logic [63:0] k, output int width, output int wait_n,
                          output bit err_after, output bit ok);
    int n = 0;
    while (seq_busy && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    key_in = k; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    err_after = err_timeout;
    width = 0;
    while (core_en_key && width < 100) begin width++; @(negedge clk); end
    wait_n = 0;
    while (!key_ready && wait_n < INIT_CYCLES + 2000) begin @(negedge clk); wait_n++; end
    ok = key_ready;
    m_key = k;
  endtask

  task automatic put_block(input logic [63:0] p, input bit enc, input bit cbc, input bit ivl,
                           input logic [63:0] iv, output bit ok);
    int n = 0;
    @(negedge clk);
    bus.s_data = p; bus.s_valid = 1'b1; dir_enc = enc; mode_cbc = cbc; iv_load = ivl; iv_in = iv;
    while (!bus.s_ready && n < 200) begin @(negedge clk); n++; end
    ok = bus.s_ready;
    if (ok) @(negedge clk);
    bus.s_valid = 1'b0; iv_load = 1'b0;
  endtask

  task automatic take_block(input int stall, output logic [63:0] got, output bit ok);
    int n = 0;
    while (!bus.m_valid && n < 300) begin @(negedge clk); n++; end
    ok = bus.m_valid; got = bus.m_data;
    if (!ok) return;
    repeat (stall) @(negedge clk);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  task automatic iv_pulse(input logic [63:0] iv);
    @(negedge clk);
    iv_in = iv; iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    m_chain = iv;
  endtask

  task automatic test_reset();
    logic [7:0] ctrl;
    int w, wn, n, mv0;
    bit e, ok;
    @(negedge clk);
    ctrl = {bus.s_ready, bus.m_valid, key_ready, seq_busy, err_timeout, core_en_key, core_en_pt, core_en_enc_dec};
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL rst_ctrl got=%b exp=00000000", ctrl); end
    checks++; if (bus.m_data !== 64'h0) begin errors++; $display("FAIL rst_mdata got=%h exp=0", bus.m_data); end
    checks++; if (core_key !== 64'h0 || core_pt !== 64'h0) begin
      errors++; $display("FAIL rst_core got key=%h pt=%h exp=0", core_key, core_pt); end
    rst = 1'b0;
    load_key(64'hA5A5_5A5A_0F0F_F0F0, w, wn, e, ok);
    put_block(64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0, 64'h0, ok);
    n = 0;
    while (!core_busy && n < 50) begin @(negedge clk); n++; end
    checks++; if (!core_busy) begin errors++; $display("FAIL rst_reach_busy got=0 exp=1"); end
    @(negedge clk);
    mv0 = mv_cnt;
    #2 rst = 1'b1;
    #1;
    ctrl = {bus.s_ready, bus.m_valid, key_ready, seq_busy, err_timeout, core_en_key, core_en_pt, core_en_enc_dec};
    checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL midrst_ctrl got=%b exp=00000000", ctrl); end
    checks++; if (bus.m_data !== 64'h0 || core_pt !== 64'h0 || core_key !== 64'h0) begin
      errors++; $display("FAIL midrst_data got m=%h pt=%h key=%h exp=0", bus.m_data, core_pt, core_key); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (mv_cnt !== mv0) begin errors++; $display("FAIL midrst_no_mvalid got=%0d exp=%0d", mv_cnt, mv0); end
    checks++; if ({seq_busy, key_ready, bus.s_ready} !== 3'b000) begin
      errors++; $display("FAIL midrst_idle got=%b exp=000", {seq_busy, key_ready, bus.s_ready}); end
    m_chain = '0;
  endtask

  task automatic test_key_load();
    int w, wn;
    bit e, ok;
    core_init_len = INIT_CYCLES + 30;
    load_key(64'h0, w, wn, e, ok);
    checks++; if (w != KEY_HOLD) begin errors++; $display("FAIL key_width got=%0d exp=%0d", w, KEY_HOLD); end
    checks++; if (!ok || wn <= core_init_len) begin
      errors++; $display("FAIL key_wait_busy got=%0d exp>%0d", wn, core_init_len); end
    core_init_len = 10;
    load_key(64'h0, w, wn, e, ok);
    checks++; if (!ok || wn < INIT_CYCLES || wn > INIT_CYCLES + 2) begin
      errors++; $display("FAIL key_wait_init got=%0d exp=%0d..%0d", wn, INIT_CYCLES, INIT_CYCLES + 2); end
    checks++; if (seq_busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL key_ready_state got busy=%b sready=%b exp 0/1", seq_busy, bus.s_ready); end
  endtask

  task automatic test_ecb();
    logic [63:0] exp, got, ct, p;
    bit ok1, ok2;
    model_step(64'h0, 1'b1, 1'b0, exp);
    put_block(64'h0, 1'b1, 1'b0, 1'b0, 64'h0, ok1);
    take_block(0, got, ok2);
    checks++; if (!ok1 || !ok2 || got !== exp) begin errors++; $display("FAIL ecb_enc0 got=%h exp=%h", got, exp); end
    checks++; if (last_pt_w != PT_HOLD) begin errors++; $display("FAIL pt_width got=%0d exp=%0d", last_pt_w, PT_HOLD); end
    ct = got;
    put_block(ct, 1'b0, 1'b0, 1'b0, 64'h0, ok1);
    take_block(1, got, ok2);
    checks++; if (!ok1 || !ok2 || got !== 64'h0) begin errors++; $display("FAIL ecb_dec0 got=%h exp=0", got); end
    for (int i = 0; i < 3; i++) begin
      p = {$urandom, $urandom};
      model_step(p, i[0], 1'b0, exp);
      put_block(p, i[0], 1'b0, 1'b0, 64'h0, ok1);
      take_block(0, got, ok2);
      checks++; if (!ok1 || !ok2 || got !== exp) begin errors++; $display("FAIL ecb_rand%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_cbc();
    logic [63:0] iv, p1, p2, c1, c2, exp, got;
    bit ok1, ok2;
    iv = 64'h0123456789ABCDEF; p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
    m_chain = iv;
    model_step(p1, 1'b1, 1'b1, exp);
    put_block(p1, 1'b1, 1'b1, 1'b1, iv, ok1);
    take_block(0, c1, ok2);
    checks++; if (!ok1 || !ok2 || c1 !== exp) begin errors++; $display("FAIL cbc_enc1 got=%h exp=%h", c1, exp); end
    model_step(p2, 1'b1, 1'b1, exp);
    put_block(p2, 1'b1, 1'b1, 1'b0, 64'h0, ok1);
    take_block(2, c2, ok2);
    checks++; if (!ok1 || !ok2 || c2 !== exp) begin errors++; $display("FAIL cbc_enc2 got=%h exp=%h", c2, exp); end
    iv_pulse(iv);
    put_block(c1, 1'b0, 1'b1, 1'b0, 64'h0, ok1);
    take_block(0, got, ok2);
    model_step(c1, 1'b0, 1'b1, exp);
    checks++; if (!ok1 || !ok2 || got !== p1) begin errors++; $display("FAIL cbc_dec1 got=%h exp=%h", got, p1); end
    put_block(c2, 1'b0, 1'b1, 1'b0, 64'h0, ok1);
    take_block(0, got, ok2);
    model_step(c2, 1'b0, 1'b1, exp);
    checks++; if (!ok1 || !ok2 || got !== p2) begin errors++; $display("FAIL cbc_dec2 got=%h exp=%h", got, p2); end
  endtask

  task automatic test_stall();
    logic [63:0] p, exp, first, got;
    int n, bad_data, bad_ready;
    bit ok1, ok2;
    p = {$urandom, $urandom};
    model_step(p, 1'b1, 1'b1, exp);
    put_block(p, 1'b1, 1'b1, 1'b0, 64'h0, ok1);
    n = 0;
    while (!bus.m_valid && n < 300) begin @(negedge clk); n++; end
    first = bus.m_data;
    checks++; if (!ok1 || !bus.m_valid || first !== exp) begin errors++; $display("FAIL stall_first got=%h exp=%h", first, exp); end
    bad_data = 0; bad_ready = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.m_data !== first || bus.m_valid !== 1'b1) bad_data++;
      if (bus.s_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0 bad cycles", bad_data); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL stall_sready got=%0d exp=0 bad cycles", bad_ready); end
    take_block(0, got, ok2);
    p = {$urandom, $urandom};
    model_step(p, 1'b1, 1'b1, exp);
    put_block(p, 1'b1, 1'b1, 1'b0, 64'h0, ok1);
    take_block(0, got, ok2);
    checks++; if (!ok1 || !ok2 || got !== exp) begin errors++; $display("FAIL stall_chain got=%h exp=%h", got, exp); end
  endtask

  task automatic test_key_ignored();
    logic [63:0] p, exp, got, key0;
    int ek0;
    bit ok1, ok2;
    key0 = m_key; p = {$urandom, $urandom};
    model_step(p, 1'b1, 1'b0, exp);
    put_block(p, 1'b1, 1'b0, 1'b0, 64'h0, ok1);
    ek0 = ek_cnt;
    key_in = ~key0; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    take_block(0, got, ok2);
    checks++; if (!ok1 || !ok2 || got !== exp) begin errors++; $display("FAIL keyign_result got=%h exp=%h", got, exp); end
    checks++; if (ek_cnt != ek0 || core_key !== key0) begin
      errors++; $display("FAIL keyign_strobe got=%0d key=%h exp=%0d key=%h", ek_cnt, core_key, ek0, key0); end
  endtask

  task automatic test_random();
    logic [63:0] p, iv, exp, got;
    bit enc, cbc, ivl, ok1, ok2, e;
    int w, wn;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(5, 0) == 0) load_key({$urandom, $urandom}, w, wn, e, ok1);
      p = {$urandom, $urandom}; iv = {$urandom, $urandom};
      enc = 1'($urandom); cbc = 1'($urandom); ivl = ($urandom_range(3, 0) == 0);
      if (ivl) m_chain = iv;
      model_step(p, enc, cbc, exp);
      put_block(p, enc, cbc, ivl, iv, ok1);
      take_block(int'($urandom_range(4, 0)), got, ok2);
      checks++; if (!ok1 || !ok2 || got !== exp) begin
        errors++; $display("FAIL rand%0d enc=%b cbc=%b iv=%b got=%h exp=%h", i, enc, cbc, ivl, got, exp); end
    end
  endtask

  task automatic test_timeout();
    logic [63:0] p, exp, got;
    int n, mv0, w, wn;
    bit ok1, ok2, e;
    core_dead = 1'b1;
    mv0 = mv_cnt;
    put_block({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'h0, ok1);
    n = 0;
    while (core_en_pt && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!err_timeout && n < BUSY_TIMEOUT + 100) begin @(negedge clk); n++; end
    checks++; if (!ok1 || n != BUSY_TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, BUSY_TIMEOUT + 1); end
    @(negedge clk);
    checks++; if (mv_cnt != mv0 || bus.s_ready !== 1'b1 || key_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_ready got mv=%0d sready=%b kr=%b exp mv=%0d 1 1", mv_cnt, bus.s_ready, key_ready, mv0); end
    core_dead = 1'b0;
    p = {$urandom, $urandom};
    model_step(p, 1'b0, 1'b0, exp);
    put_block(p, 1'b0, 1'b0, 1'b0, 64'h0, ok1);
    take_block(0, got, ok2);
    checks++; if (!ok1 || !ok2 || got !== exp) begin errors++; $display("FAIL timeout_next got=%h exp=%h", got, exp); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
    load_key({$urandom, $urandom}, w, wn, e, ok1);
    checks++; if (e !== 1'b0 || !ok1) begin errors++; $display("FAIL timeout_clear got=%b exp=0", e); end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_key_load();
    test_ecb();
    test_cbc();
    test_stall();
    test_key_ignored();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
